// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// (req0) and load-return (req1) write-back paths, with a registered write stage.
module reg_wr_arbiter #(
    parameter int WORD_SIZE      = 32,
    parameter int WRITE_REG_SIZE = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_stall,
    input  logic                      i_req0_valid,
    input  logic [WRITE_REG_SIZE-1:0] i_req0_reg,
    input  logic [WORD_SIZE-1:0]      i_req0_data,
    output logic                      o_req0_ready,
    input  logic                      i_req1_valid,
    input  logic [WRITE_REG_SIZE-1:0] i_req1_reg,
    input  logic [WORD_SIZE-1:0]      i_req1_data,
    output logic                      o_req1_ready,
    output logic                      o_reg_wr,
    output logic [WRITE_REG_SIZE-1:0] o_wr_reg,
    output logic [WORD_SIZE-1:0]      o_wr_data,
    output logic [7:0]                o_conflict_cnt
);

    logic                      last_grant;
    logic                      grant0;
    logic                      grant1;
    logic                      accept;
    logic                      contended;
    logic                      acc_nonzero;
    logic [WRITE_REG_SIZE-1:0] acc_reg;
    logic [WORD_SIZE-1:0]      acc_data;

    // On contention the requester that did not win most recently gets the port.
    always_comb begin
        grant0      = 1'b0;
        grant1      = 1'b0;
        acc_reg     = '0;
        acc_data    = '0;
        contended   = i_req0_valid && i_req1_valid && !i_stall;
        if (!i_stall) begin
            if (i_req0_valid && i_req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = i_req0_valid;
                grant1 = i_req1_valid;
            end
        end
        accept = grant0 || grant1;
        if (grant1) begin
            acc_reg  = i_req1_reg;
            acc_data = i_req1_data;
        end else begin
            acc_reg  = i_req0_reg;
            acc_data = i_req0_data;
        end
        acc_nonzero = accept && (acc_reg != '0);
    end

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            last_grant     <= 1'b1;
            o_reg_wr       <= 1'b0;
            o_wr_reg       <= '0;
            o_wr_data      <= '0;
            o_conflict_cnt <= '0;
        end else begin
            o_reg_wr <= acc_nonzero;
            // Writes to register 0 complete the handshake but never reach the port.
            if (acc_nonzero) begin
                o_wr_reg  <= acc_reg;
                o_wr_data <= acc_data;
            end
            if (accept) begin
                last_grant <= grant1;
            end
            if (contended && (o_conflict_cnt != 8'hFF)) begin
                o_conflict_cnt <= o_conflict_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed and randomized checks of reg_wr_arbiter against a behavioural
// model of the grant/write-back rules.
module tb_reg_wr_arbiter;

    logic        i_clk;
    logic        i_rst;
    logic        i_stall;
    logic        i_req0_valid;
    logic [4:0]  i_req0_reg;
    logic [31:0] i_req0_data;
    logic        o_req0_ready;
    logic        i_req1_valid;
    logic [4:0]  i_req1_reg;
    logic [31:0] i_req1_data;
    logic        o_req1_ready;
    logic        o_reg_wr;
    logic [4:0]  o_wr_reg;
    logic [31:0] o_wr_data;
    logic [7:0]  o_conflict_cnt;

    reg_wr_arbiter #(.WORD_SIZE(32), .WRITE_REG_SIZE(5)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_stall        (i_stall),
        .i_req0_valid   (i_req0_valid),
        .i_req0_reg     (i_req0_reg),
        .i_req0_data    (i_req0_data),
        .o_req0_ready   (o_req0_ready),
        .i_req1_valid   (i_req1_valid),
        .i_req1_reg     (i_req1_reg),
        .i_req1_data    (i_req1_data),
        .o_req1_ready   (o_req1_ready),
        .o_reg_wr       (o_reg_wr),
        .o_wr_reg       (o_wr_reg),
        .o_wr_data      (o_wr_data),
        .o_conflict_cnt (o_conflict_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: who has priority on the next tie, and the expected port.
    int          m_prio;
    logic        m_wr;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prio = 0;
        m_wr   = 1'b0;
        m_reg  = '0;
        m_data = '0;
        m_cnt  = 0;
    endtask

    task automatic step(input logic st,
                        input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                        output logic g0, output logic g1);
        @(negedge i_clk);
        i_stall = st;
        i_req0_valid = v0; i_req0_reg = r0; i_req0_data = d0;
        i_req1_valid = v1; i_req1_reg = r1; i_req1_data = d1;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!st) begin
            if (v0 && v1) begin
                g0 = (m_prio == 0);
                g1 = (m_prio == 1);
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        check("req0_ready", {31'd0, o_req0_ready}, {31'd0, g0});
        check("req1_ready", {31'd0, o_req1_ready}, {31'd0, g1});
        @(posedge i_clk);
        m_wr = 1'b0;
        if (g0 || g1) begin
            m_prio = g0 ? 1 : 0;
            if ((g0 ? r0 : r1) != 5'd0) begin
                m_wr   = 1'b1;
                m_reg  = g0 ? r0 : r1;
                m_data = g0 ? d0 : d1;
            end
        end
        if (v0 && v1 && !st) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        #1;
        check("reg_wr",   {31'd0, o_reg_wr}, {31'd0, m_wr});
        check("wr_reg",   {27'd0, o_wr_reg}, {27'd0, m_reg});
        check("wr_data",  o_wr_data, m_data);
        check("conflict", {24'd0, o_conflict_cnt}, m_cnt[31:0]);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_reg_wr"},  {31'd0, o_reg_wr}, 32'd0);
        check({tag, "_wr_reg"},  {27'd0, o_wr_reg}, 32'd0);
        check({tag, "_wr_data"}, o_wr_data, 32'd0);
        check({tag, "_cnt"},     {24'd0, o_conflict_cnt}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b0;
        i_stall = 1'b0; i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        model_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
    endtask

    logic        g0, g1;
    logic        p0, p1;
    logic [4:0]  pr0, pr1;
    logic [31:0] pd0, pd1;
    logic        st;

    initial begin
        i_rst = 1'b0;
        i_stall = 1'b0;
        i_req0_valid = 1'b0; i_req0_reg = '0; i_req0_data = '0;
        i_req1_valid = 1'b0; i_req1_reg = '0; i_req1_data = '0;
        model_reset();
        #12;
        check_zero_outputs("reset");
        @(negedge i_clk);
        i_rst = 1'b1;

        // Single requester, then idle
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, g0, g1);
        check("t1_pulse", {31'd0, o_reg_wr}, 32'd1);
        check("t1_data", o_wr_data, 32'hDEADBEEF);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g0, g1);
        check("t1_pulse_end", {31'd0, o_reg_wr}, 32'd0);

        // Alternating contention from a fresh reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, g0, g1);
            check("t2_alt_grant", {31'd0, g0}, {31'd0, ((i % 2) == 0)});
            check("t2_alt_reg", {27'd0, o_wr_reg}, ((i % 2) == 0) ? 32'd1 : 32'd2);
        end
        check("t2_cnt", {24'd0, o_conflict_cnt}, 32'd4);

        // Register-0 write from req1 handshakes without a port write
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, g0, g1);
        check("t3_ready1", {31'd0, o_req1_ready}, 32'd1);
        check("t3_no_wr", {31'd0, o_reg_wr}, 32'd0);
        check("t3_data_hold", o_wr_data, 32'h22);

        // Stall blocks grants and counting, then req0 wins
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, g0, g1);
        check("t4_cnt_hold", {24'd0, o_conflict_cnt}, 32'd4);
        step(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, g0, g1);
        check("t4_req0_wins", {27'd0, o_wr_reg}, 32'd3);

        // Counter saturation
        for (int i = 0; i < 300; i++)
            step(1'b0, 1'b1, 5'd6, 32'h66 + i, 1'b1, 5'd7, 32'h77 + i, g0, g1);
        check("t5_saturate", {24'd0, o_conflict_cnt}, 32'd255);

        // Async reset while an accepted write sits in the output stage
        do_reset();
        @(negedge i_clk);
        i_req0_valid = 1'b1; i_req0_reg = 5'd9; i_req0_data = 32'hCAFEF00D;
        @(posedge i_clk);
        #1;
        check("t6_pulse", {31'd0, o_reg_wr}, 32'd1);
        #1;
        i_rst = 1'b0;
        i_req0_valid = 1'b0;
        model_reset();
        #1;
        check_zero_outputs("t6_async");
        @(negedge i_clk);
        i_rst = 1'b1;
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g0, g1);
        step(1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 1'b1, 5'd10, 32'h1010, g0, g1);
        check("t6_first_tie", {31'd0, g0}, 32'd1);

        // Randomized traffic; requesters hold a request until it is accepted
        p0 = 1'b0; p1 = 1'b0;
        pr0 = '0; pr1 = '0; pd0 = '0; pd1 = '0;
        for (int i = 0; i < 2000; i++) begin
            if (!p0 && ($urandom_range(1, 0) == 1)) begin
                p0 = 1'b1; pr0 = 5'($urandom_range(31, 0)); pd0 = $urandom;
            end
            if (!p1 && ($urandom_range(1, 0) == 1)) begin
                p1 = 1'b1; pr1 = 5'($urandom_range(31, 0)); pd1 = $urandom;
            end
            st = ($urandom_range(4, 0) == 0);
            step(st, p0, pr0, pd0, p1, pr1, pd1, g0, g1);
            if (g0) p0 = 1'b0;
            if (g1) p1 = 1'b0;
            if (i == 1000) begin
                do_reset();
                p0 = 1'b0; p1 = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
